// File: rtl/resizer_pkg.sv
// ============================================================================
// Module      : resizer_pkg
// Description : Shared geometry, state encoding and pixel field layout for
//               the camera-side resizer and the display-side frame_upscaler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package resizer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int OUTPUT_WIDTH     = 640;
  localparam int OUTPUT_HEIGHT    = 480;
  localparam int VERT_CROP_COUNT  = 16;
  localparam int HORIZ_CROP_COUNT = 96;
  localparam int IN_DIM           = 224;

  localparam int INNER_ROW_FIRST = VERT_CROP_COUNT;
  localparam int INNER_ROW_LAST  = OUTPUT_HEIGHT - VERT_CROP_COUNT - 1;
  localparam int INNER_COL_FIRST = HORIZ_CROP_COUNT;
  localparam int INNER_COL_LAST  = OUTPUT_WIDTH - HORIZ_CROP_COUNT - 1;

  localparam int CHANNEL_WIDTH = 8;
  localparam int PIXEL_WIDTH   = 3 * CHANNEL_WIDTH;
  localparam int RED_LSB       = 0;
  localparam int GREEN_LSB     = 8;
  localparam int BLUE_LSB      = 16;

  function automatic logic [PIXEL_WIDTH-1:0] packPixel(
    input logic [CHANNEL_WIDTH-1:0] red,
    input logic [CHANNEL_WIDTH-1:0] green,
    input logic [CHANNEL_WIDTH-1:0] blue
  );
    logic [PIXEL_WIDTH-1:0] pixel;
    pixel = '0;
    pixel[RED_LSB   +: CHANNEL_WIDTH] = red;
    pixel[GREEN_LSB +: CHANNEL_WIDTH] = green;
    pixel[BLUE_LSB  +: CHANNEL_WIDTH] = blue;
    return pixel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/upscaler_line_buffer.sv
// ============================================================================
// Module      : upscaler_line_buffer
// Description : One input line of pixels; synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module upscaler_line_buffer #(
  parameter int DEPTH  = 224,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  writeData,
  input  logic [ADDR_W-1:0] readAddr,
  output logic [WIDTH-1:0]  readData
);

  // No reset: every entry is written on the even row before the odd row reads it.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (writeEnable) begin
      r_mem[writeAddr] <= writeData;
    end
  end

  assign readData = r_mem[readAddr];

endmodule

`default_nettype wire

// File: rtl/frame_upscaler.sv
// ============================================================================
// Module      : frame_upscaler
// Description : 2x2 nearest-neighbour upscale of an IN_DIM square image, with
//               optional constant-colour crop border (FRAME_UPSCALER_BORDER_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_upscaler #(
  parameter int                    DATA_WIDTH       = resizer_pkg::PIXEL_WIDTH,
  parameter int                    OUTPUT_WIDTH     = resizer_pkg::OUTPUT_WIDTH,
  parameter int                    OUTPUT_HEIGHT    = resizer_pkg::OUTPUT_HEIGHT,
  parameter int                    VERT_CROP_COUNT  = resizer_pkg::VERT_CROP_COUNT,
  parameter int                    HORIZ_CROP_COUNT = resizer_pkg::HORIZ_CROP_COUNT,
  parameter int                    IN_DIM           = resizer_pkg::IN_DIM,
  parameter logic [DATA_WIDTH-1:0] BORDER_COLOR     = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  startNewImage,
  input  logic [7:0]            inRed,
  input  logic [7:0]            inGreen,
  input  logic [7:0]            inBlue,
  input  logic                  inPixelValid,
  output logic                  inReady,
  output logic [DATA_WIDTH-1:0] outPixelData,
  output logic                  outPixelValid,
  input  logic                  outReady,
  output logic                  endOfImage
);

  import resizer_pkg::*;

`ifdef FRAME_UPSCALER_BORDER_EN
  localparam int RASTER_W = OUTPUT_WIDTH;
  localparam int RASTER_H = OUTPUT_HEIGHT;
  localparam int ROW_OFF  = VERT_CROP_COUNT;
  localparam int COL_OFF  = HORIZ_CROP_COUNT;
`else
  // Without the border the raster collapses to the inner 2*IN_DIM square.
  localparam int RASTER_W = OUTPUT_WIDTH - 2 * HORIZ_CROP_COUNT;
  localparam int RASTER_H = OUTPUT_HEIGHT - 2 * VERT_CROP_COUNT;
  localparam int ROW_OFF  = 0;
  localparam int COL_OFF  = 0;
`endif

  localparam int   CNT_W       = $clog2(RASTER_W > RASTER_H ? RASTER_W : RASTER_H);
  localparam int   ADDR_W      = $clog2(IN_DIM);
  localparam int   ICOL_W      = ADDR_W + 1;
  localparam logic ROW_OFF_ODD = (ROW_OFF % 2) != 0;

  state_t                r_state;
  logic [CNT_W-1:0]      r_rowCounter;
  logic [CNT_W-1:0]      r_colCounter;
  logic [DATA_WIDTH-1:0] r_pairReg;

  logic                  w_inner;
  logic                  w_rowOdd;
  logic [ICOL_W-1:0]     w_innerCol;
  logic                  w_fetch;
  logic                  w_transfer;
  logic [DATA_WIDTH-1:0] w_inPixel;
  logic [DATA_WIDTH-1:0] w_lineData;

  assign w_inPixel = DATA_WIDTH'(packPixel(inRed, inGreen, inBlue));

  // Only parity of the inner row and the low bits of the inner column matter,
  // so the offset subtraction is done modulo 2^ICOL_W.
  assign w_rowOdd   = r_rowCounter[0] ^ ROW_OFF_ODD;
  assign w_innerCol = r_colCounter[ICOL_W-1:0] - ICOL_W'(COL_OFF);

`ifdef FRAME_UPSCALER_BORDER_EN
  assign w_inner = (r_rowCounter >= CNT_W'(ROW_OFF))
                && (r_rowCounter <  CNT_W'(ROW_OFF + 2 * IN_DIM))
                && (r_colCounter >= CNT_W'(COL_OFF))
                && (r_colCounter <  CNT_W'(COL_OFF + 2 * IN_DIM));
`else
  assign w_inner = 1'b1;
`endif

  always_comb begin
    outPixelData  = '0;
    outPixelValid = 1'b0;
    inReady       = 1'b0;
    w_fetch       = 1'b0;
    if (r_state == ACTIVE) begin
      if (!w_inner) begin
        outPixelData  = BORDER_COLOR;
        outPixelValid = 1'b1;
      end else if (!w_rowOdd && !w_innerCol[0]) begin
        outPixelData  = w_inPixel;
        outPixelValid = inPixelValid;
        inReady       = outReady;
        w_fetch       = 1'b1;
      end else if (!w_rowOdd) begin
        outPixelData  = r_pairReg;
        outPixelValid = 1'b1;
      end else begin
        outPixelData  = w_lineData;
        outPixelValid = 1'b1;
      end
    end
  end

  assign w_transfer = outPixelValid && outReady;
  assign endOfImage = (r_state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rowCounter <= '0;
      r_colCounter <= '0;
      r_pairReg    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (startNewImage) begin
            r_state      <= ACTIVE;
            r_rowCounter <= '0;
            r_colCounter <= '0;
          end
        end
        ACTIVE: begin
          if (w_transfer) begin
            if (w_fetch) begin
              r_pairReg <= w_inPixel;
            end
            if (r_colCounter == CNT_W'(RASTER_W - 1)) begin
              r_colCounter <= '0;
              if (r_rowCounter == CNT_W'(RASTER_H - 1)) begin
                r_rowCounter <= '0;
                r_state      <= DONE;
              end else begin
                r_rowCounter <= r_rowCounter + 1'b1;
              end
            end else begin
              r_colCounter <= r_colCounter + 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  upscaler_line_buffer #(
    .DEPTH (IN_DIM),
    .WIDTH (DATA_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_lineBuffer (
    .clock      (clock),
    .writeEnable(w_fetch && w_transfer),
    .writeAddr  (w_innerCol[ADDR_W:1]),
    .writeData  (w_inPixel),
    .readAddr   (w_innerCol[ADDR_W:1]),
    .readData   (w_lineData)
  );

endmodule

`default_nettype wire

// File: tb/tb_frame_upscaler.sv
// ============================================================================
// Module      : tb_frame_upscaler
// Description : Scoreboard bench for frame_upscaler on a reduced geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_upscaler;

  localparam int          IN_DIM = 4;
  localparam int          HC     = 3;
  localparam int          VC     = 2;
  localparam int          OW     = 2 * IN_DIM + 2 * HC;
  localparam int          OH     = 2 * IN_DIM + 2 * VC;
  localparam logic [23:0] BC     = 24'hA5C3E1;

`ifdef FRAME_UPSCALER_BORDER_EN
  localparam int RW = OW, RH = OH, ROFF = VC, COFF = HC;
`else
  localparam int RW = 2 * IN_DIM, RH = 2 * IN_DIM, ROFF = 0, COFF = 0;
`endif
  localparam int TOTAL  = RW * RH;
  localparam int BUDGET = 4000;

  logic        clock = 1'b0;
  logic        reset, startNewImage, inPixelValid, outReady;
  logic [7:0]  inRed, inGreen, inBlue;
  logic        inReady, outPixelValid, endOfImage;
  logic [23:0] outPixelData;

  frame_upscaler #(
    .DATA_WIDTH      (24),
    .OUTPUT_WIDTH    (OW),
    .OUTPUT_HEIGHT   (OH),
    .VERT_CROP_COUNT (VC),
    .HORIZ_CROP_COUNT(HC),
    .IN_DIM          (IN_DIM),
    .BORDER_COLOR    (BC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .startNewImage(startNewImage),
    .inRed        (inRed),
    .inGreen      (inGreen),
    .inBlue       (inBlue),
    .inPixelValid (inPixelValid),
    .inReady      (inReady),
    .outPixelData (outPixelData),
    .outPixelValid(outPixelValid),
    .outReady     (outReady),
    .endOfImage   (endOfImage)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] expQ[$];
  bit          monEn = 1'b0;
  int          monIdx = 0;
  logic        prevHeld = 1'b0;
  logic [23:0] prevData = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] expectedAt(input int r, input int c);
    int ir, ic;
    if (r < ROFF || r >= ROFF + 2 * IN_DIM || c < COFF || c >= COFF + 2 * IN_DIM)
      return BC;
    ir = r - ROFF;
    ic = c - COFF;
    return 24'((ir / 2) * IN_DIM + ic / 2);
  endfunction

  task automatic drivePixel(input int k);
    logic [23:0] p;
    p       = 24'(k);
    inRed   = p[7:0];
    inGreen = p[15:8];
    inBlue  = p[23:16];
  endtask

  // Monitor: sampled 2 time units after the falling edge, well clear of posedge.
  always @(negedge clock) begin
    #2;
    if (monEn) begin
      if (outPixelValid && prevHeld)
        check("hold_stable", outPixelData, prevData);
      if (outPixelValid && outReady) begin
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: actual %0h required none", outPixelData);
        end else begin
          check($sformatf("pixel[%0d]", monIdx), outPixelData, expQ.pop_front());
          monIdx++;
        end
      end
      prevHeld = outPixelValid && !outReady;
      prevData = outPixelData;
    end else begin
      prevHeld = 1'b0;
    end
  end

  // mode 0: plain, 1: random outReady, 2: input stall, 3: start pulses mid-frame
  task automatic runFrame(input int mode);
    int   k, xfers, cyc, stallLeft, stallIdx;
    logic xfer, acc, stalled;
    k = 0; xfers = 0; cyc = 0; stallLeft = 5;
    stallIdx = ROFF * RW + COFF + 4;
    expQ.delete();
    for (int r = 0; r < RH; r++)
      for (int c = 0; c < RW; c++)
        expQ.push_back(expectedAt(r, c));
    monIdx = 0;
    monEn  = 1'b1;
    @(negedge clock);
    startNewImage = 1'b1;
    outReady      = 1'b1;
    inPixelValid  = 1'b1;
    drivePixel(0);
    @(posedge clock);
    while (xfers < TOTAL && cyc < BUDGET) begin
      @(negedge clock);
      startNewImage = (mode == 3) && (cyc % 7 == 3);
      outReady      = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled       = (mode == 2) && (xfers == stallIdx) && (stallLeft > 0);
      inPixelValid  = !stalled;
      drivePixel(k);
      #1;
      if (stalled) begin
        check("stall_out_valid", outPixelValid, 0);
        stallLeft--;
      end
      xfer = outPixelValid && outReady;
      acc  = inReady && inPixelValid;
      @(posedge clock);
      if (xfer) xfers++;
      if (acc) k++;
      cyc++;
    end
    if (xfers < TOTAL) begin
      errors++;
      $display("FAIL frame_timeout: actual %0d transfers required %0d", xfers, TOTAL);
    end
    @(negedge clock);
    startNewImage = 1'b0;
    #1;
    check($sformatf("eoi_high_mode%0d", mode), endOfImage, 1);
    check($sformatf("input_accepts_mode%0d", mode), k, IN_DIM * IN_DIM);
    @(negedge clock);
    #1;
    check($sformatf("eoi_low_mode%0d", mode), endOfImage, 0);
    check($sformatf("idle_valid_mode%0d", mode), outPixelValid, 0);
    monEn = 1'b0;
    check($sformatf("queue_drained_mode%0d", mode), expQ.size(), 0);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_outPixelValid"}, outPixelValid, 0);
    check({tag, "_inReady"}, inReady, 0);
    check({tag, "_endOfImage"}, endOfImage, 0);
    check({tag, "_outPixelData"}, outPixelData, 0);
  endtask

  initial begin
    reset = 1'b1; startNewImage = 1'b0; inPixelValid = 1'b0; outReady = 1'b0;
    drivePixel(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checkIdle("reset");
    reset        = 1'b0;
    inPixelValid = 1'b1;
    outReady     = 1'b1;
    drivePixel(7);
    @(negedge clock);
    #1;
    checkIdle("idle");

    runFrame(0);
    runFrame(1);
    runFrame(2);
    runFrame(3);

    // Abort a frame with reset held for 3 cycles.
    @(negedge clock);
    startNewImage = 1'b1; outReady = 1'b1; inPixelValid = 1'b1;
    drivePixel(0);
    @(negedge clock);
    startNewImage = 1'b0;
    repeat (20) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checkIdle("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      checkIdle($sformatf("postreset%0d", i));
    end

    runFrame(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
